alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 16-bit registered ALU for the accumulator datapath.
- Operand A is the accumulator (`acc`) and operand B is the bus value (`b_bus`).
- A 5-bit opcode selects one of 24 operations; the result and the Z/N/O flags are registered on `clk_100`.
- Downstream, the result feeds the accumulator write-back and the flags feed the control unit's branch logic.

Parameters:
- WIDTH, 16, datapath width; all widths below assume 16.

Ports:
- clk_100  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- b_bus  input  16  operand B
- acc  input  16  operand A
- ctrl  input  5  opcode
- out  output  16  registered result
- z  output  1  registered zero flag
- n  output  1  registered negative flag
- o  output  1  registered overflow flag

Behaviour:
- Reset: one clock, `clk_100`; reset is asynchronous and active-high. While `rst`=1, `out`=0, `z`=0, `n`=0, `o`=0, independent of the clock.
- Timing: combinational result from `acc`, `b_bus` and `ctrl` is captured on every rising edge when `rst`=0. Latency is 1 cycle, with no handshake and no enable.
- Opcodes (A=`acc`, B=`b_bus`; all arithmetic mod 2^16):
  - 0: 0
  - 1: 1
  - 2: 16'hFFFF (-1)
  - 3: 128
  - 4: A
  - 5: B
  - 6: -A (two's complement)
  - 7: -B
  - 8: ~A
  - 9: ~B
  - 10: A+B
  - 11: A-B
  - 12: A*B, low 16 bits of the unsigned 32-bit product
  - 13: A+1
  - 14: A-1
  - 15: B+1
  - 16: B-1
  - 17: A&B
  - 18: A|B
  - 19: A^B
  - 20: A<<1, LSB filled with 0; B ignored
  - 21: A>>1, logical, MSB filled with 0; B ignored
  - 22: (A<B) ? 1 : 0, unsigned compare
  - 23: (A>B) ? 1 : 0, unsigned compare
  - 24-31: result 0
- z: 1 iff the next `out` value is 0.
- n: equals bit 15 of the next `out` value.
- o, two's-complement signed overflow:
  - Opcodes 10, 13, 15: set when both operands have the same sign and the result sign differs.
  - Opcodes 11, 14, 16: set when the operands have different signs and the result sign differs from the minuend.
  - Opcodes 6, 7: set when the operand is 16'h8000.
  - Opcode 12: set when the upper 16 product bits are nonzero.
  - All other opcodes: o=0.
- Carry-out is not exported.
- Flags update every cycle together with `out`; there is no flag hold.
- Reset released mid-stream: the first rising edge after deassertion captures the current inputs.

Test Plan:
- Reset: assert `rst` asynchronously with `ctrl`=10, A=12, B=15 -> `out`=0 and z=n=o=0 immediately; deassert -> after one edge `out`=27, z=0, n=0, o=0.
- Constants and moves: ctrl 0/1/2/3/4/5 with A=12, B=15 -> `out` 0 (z=1), 1, 16'hFFFF (n=1), 128, 12, 15, each one cycle after the input change.
- Add/sub wrap: ctrl=10, A=1, B=16'hFFFF -> `out`=0, z=1, o=0. ctrl=11, A=12, B=12 -> `out`=0, z=1. ctrl=10, A=16'h7FFF, B=1 -> `out`=16'h8000, n=1, o=1.
- Unary arithmetic: A=12, B=15 with ctrl 6/7/8/9 -> 16'hFFF4, 16'hFFF1, 16'hFFF3, 16'hFFF0, all with n=1. With ctrl 13/14/15/16 -> 13, 11, 16, 14. ctrl=14 with A=16'h8000 -> `out`=16'h7FFF, o=1.
- Multiply and logic: A=12, B=15 with ctrl 12 -> 180, o=0; ctrl 17 -> 12; ctrl 18 -> 15; ctrl 19 -> 3. ctrl=12 with A=B=16'h0100 -> `out`=0, z=1, o=1.
- Shift and compare: A=12 with ctrl 20 -> 24; ctrl 21 -> 6. A=12, B=2 with ctrl 22 -> 0, z=1; ctrl 23 -> 1. ctrl=27 -> 0, z=1.

Source files
------------

// File: rtl/alu_unit_if.sv
// Operand/result bundle between the accumulator datapath and the ALU.
// master drives the operands and opcode; slave returns the registered result and flags.
interface alu_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] b_bus;
    logic [WIDTH-1:0] acc;
    logic [4:0]       ctrl;
    logic [WIDTH-1:0] out;
    logic             z;
    logic             n;
    logic             o;

    modport master (
        output b_bus,
        output acc,
        output ctrl,
        input  out,
        input  z,
        input  n,
        input  o
    );

    modport slave (
        input  b_bus,
        input  acc,
        input  ctrl,
        output out,
        output z,
        output n,
        output o
    );
endinterface

// File: rtl/alu_unit.sv
// Registered ALU for the accumulator datapath: 24 opcodes, result plus Z/N/O flags
// captured every rising clk_100 edge with one cycle of latency.
module alu_unit #(
    parameter int unsigned WIDTH = 16
) (
    input logic       clk_100,
    input logic       rst,
    alu_unit_if.slave bus
);
    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_d;
    logic               ovf_d;
    logic [WIDTH-1:0]   out_q;
    logic               z_q;
    logic               n_q;
    logic               o_q;

    assign a    = bus.acc;
    assign b    = bus.b_bus;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (bus.ctrl)
            5'd0:  res_d = '0;
            5'd1:  res_d = WIDTH'(1);
            5'd2:  res_d = '1;
            5'd3:  res_d = WIDTH'(128);
            5'd4:  res_d = a;
            5'd5:  res_d = b;
            5'd6: begin
                res_d = '0 - a;
                ovf_d = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            5'd7: begin
                res_d = '0 - b;
                ovf_d = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            5'd8:  res_d = ~a;
            5'd9:  res_d = ~b;
            5'd10: begin
                res_d = a + b;
                ovf_d = (a[Msb] == b[Msb]) && (res_d[Msb] != a[Msb]);
            end
            5'd11: begin
                res_d = a - b;
                ovf_d = (a[Msb] != b[Msb]) && (res_d[Msb] != a[Msb]);
            end
            5'd12: begin
                res_d = prod[WIDTH-1:0];
                ovf_d = |prod[2*WIDTH-1:WIDTH];
            end
            // The constant 1 operand is positive, so only the variable operand's sign matters.
            5'd13: begin
                res_d = a + WIDTH'(1);
                ovf_d = !a[Msb] && res_d[Msb];
            end
            5'd14: begin
                res_d = a - WIDTH'(1);
                ovf_d = a[Msb] && !res_d[Msb];
            end
            5'd15: begin
                res_d = b + WIDTH'(1);
                ovf_d = !b[Msb] && res_d[Msb];
            end
            5'd16: begin
                res_d = b - WIDTH'(1);
                ovf_d = b[Msb] && !res_d[Msb];
            end
            5'd17: res_d = a & b;
            5'd18: res_d = a | b;
            5'd19: res_d = a ^ b;
            5'd20: res_d = {a[WIDTH-2:0], 1'b0};
            5'd21: res_d = {1'b0, a[WIDTH-1:1]};
            5'd22: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            5'd23: res_d = {{(WIDTH-1){1'b0}}, (a > b)};
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            o_q   <= 1'b0;
        end else begin
            out_q <= res_d;
            z_q   <= (res_d == '0);
            n_q   <= res_d[Msb];
            o_q   <= ovf_d;
        end
    end

    assign bus.out = out_q;
    assign bus.z   = z_q;
    assign bus.n   = n_q;
    assign bus.o   = o_q;
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: hand-computed results and flags, including
// asynchronous reset assertion between clock edges.
module tb_alu_unit;
    logic clk_100;
    logic rst;
    int   n_vec;
    int   n_miss;

    alu_unit_if #(.WIDTH(16)) bus ();

    alu_unit #(.WIDTH(16)) dut (
        .clk_100(clk_100),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out, input logic e_z,
                             input logic e_n, input logic e_o);
        check({tag, ".out"}, 32'(bus.out), 32'(e_out));
        check({tag, ".z"},   32'(bus.z),   32'(e_z));
        check({tag, ".n"},   32'(bus.n),   32'(e_n));
        check({tag, ".o"},   32'(bus.o),   32'(e_o));
    endtask

    // Drive just after an edge, then sample 1 time unit after the next capturing edge.
    task automatic run(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e_out, input logic e_z, input logic e_n,
                       input logic e_o);
        bus.ctrl  = op;
        bus.acc   = a;
        bus.b_bus = b;
        @(posedge clk_100);
        #1;
        check_all($sformatf("op%0d_a%0h_b%0h", op, a, b), e_out, e_z, e_n, e_o);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst       = 1'b1;
        bus.ctrl  = 5'd10;
        bus.acc   = 16'd12;
        bus.b_bus = 16'd15;
        #2;
        check_all("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        #5;
        rst = 1'b0;
        @(posedge clk_100);
        #1;
        check_all("post_reset", 16'd27, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk_100);
        #1;

        run(5'd0,  16'd12,   16'd15,   16'h0000, 1'b1, 1'b0, 1'b0);
        run(5'd1,  16'd12,   16'd15,   16'h0001, 1'b0, 1'b0, 1'b0);
        run(5'd2,  16'd12,   16'd15,   16'hFFFF, 1'b0, 1'b1, 1'b0);
        run(5'd3,  16'd12,   16'd15,   16'd128,  1'b0, 1'b0, 1'b0);
        run(5'd4,  16'd12,   16'd15,   16'd12,   1'b0, 1'b0, 1'b0);
        run(5'd5,  16'd12,   16'd15,   16'd15,   1'b0, 1'b0, 1'b0);
        run(5'd10, 16'd1,    16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        run(5'd11, 16'd12,   16'd12,   16'h0000, 1'b1, 1'b0, 1'b0);
        run(5'd10, 16'h7FFF, 16'd1,    16'h8000, 1'b0, 1'b1, 1'b1);
        run(5'd11, 16'h8000, 16'd1,    16'h7FFF, 1'b0, 1'b0, 1'b1);
        run(5'd6,  16'd12,   16'd15,   16'hFFF4, 1'b0, 1'b1, 1'b0);
        run(5'd7,  16'd12,   16'd15,   16'hFFF1, 1'b0, 1'b1, 1'b0);
        run(5'd8,  16'd12,   16'd15,   16'hFFF3, 1'b0, 1'b1, 1'b0);
        run(5'd9,  16'd12,   16'd15,   16'hFFF0, 1'b0, 1'b1, 1'b0);
        run(5'd6,  16'h8000, 16'd15,   16'h8000, 1'b0, 1'b1, 1'b1);
        run(5'd13, 16'd12,   16'd15,   16'd13,   1'b0, 1'b0, 1'b0);
        run(5'd14, 16'd12,   16'd15,   16'd11,   1'b0, 1'b0, 1'b0);
        run(5'd15, 16'd12,   16'd15,   16'd16,   1'b0, 1'b0, 1'b0);
        run(5'd16, 16'd12,   16'd15,   16'd14,   1'b0, 1'b0, 1'b0);
        run(5'd14, 16'h8000, 16'd15,   16'h7FFF, 1'b0, 1'b0, 1'b1);
        run(5'd15, 16'd12,   16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b1);
        run(5'd16, 16'd12,   16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run(5'd12, 16'd12,   16'd15,   16'd180,  1'b0, 1'b0, 1'b0);
        run(5'd17, 16'd12,   16'd15,   16'd12,   1'b0, 1'b0, 1'b0);
        run(5'd18, 16'd12,   16'd15,   16'd15,   1'b0, 1'b0, 1'b0);
        run(5'd19, 16'd12,   16'd15,   16'd3,    1'b0, 1'b0, 1'b0);
        run(5'd12, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1);
        run(5'd20, 16'd12,   16'd15,   16'd24,   1'b0, 1'b0, 1'b0);
        run(5'd21, 16'd12,   16'd15,   16'd6,    1'b0, 1'b0, 1'b0);
        run(5'd21, 16'h8000, 16'd15,   16'h4000, 1'b0, 1'b0, 1'b0);
        run(5'd20, 16'hC001, 16'd15,   16'h8002, 1'b0, 1'b1, 1'b0);
        run(5'd22, 16'd12,   16'd2,    16'h0000, 1'b1, 1'b0, 1'b0);
        run(5'd23, 16'd12,   16'd2,    16'h0001, 1'b0, 1'b0, 1'b0);
        run(5'd22, 16'd2,    16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run(5'd27, 16'd12,   16'd15,   16'h0000, 1'b1, 1'b0, 1'b0);
        run(5'd24, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
